mdu_iter: RTL and testbench

//  Iterative RV64M multiply/divide unit in the execute stage, beside the single-cycle ALU.

---
 rtl/mdu_iter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MDU_FAST_MUL_EN to compute all multiplies with a single-cycle combinational product.
module mdu_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_c,
    output logic            busy
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_FULL = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_W    = CW'(31);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic op_legal(input logic [3:0] o);
        logic ok;
        case (o)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: ok = 1'b1;
            4'd8, 4'd12, 4'd13, 4'd14, 4'd15:               ok = (XLEN == 64);
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic a_signed(input logic [3:0] o);
        logic s;
        case (o)
            4'd1, 4'd2, 4'd4, 4'd6, 4'd12, 4'd14: s = 1'b1;
            default:                              s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic b_signed(input logic [3:0] o);
        logic s;
        case (o)
            4'd1, 4'd4, 4'd6, 4'd12, 4'd14: s = 1'b1;
            default:                        s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic [XLEN-1:0] res;
        res       = {XLEN{x[31]}};
        res[31:0] = x;
        return res;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
        logic [XLEN-1:0] res;
        res       = ZERO;
        res[31:0] = x;
        return res;
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic neg, input logic w);
        logic [31:0] x32;
        x32 = neg ? (32'd0 - x[31:0]) : x[31:0];
        return w ? zext32(x32) : (neg ? (ZERO - x) : x);
    endfunction

    // W products sit at bit XLEN-32 of p because only 32 shift steps were taken.
    function automatic logic [XLEN-1:0] mul_result(input logic [2*XLEN-1:0] p, input logic neg,
                                                   input logic [3:0] o);
        logic [2*XLEN-1:0] pf;
        logic [XLEN-1:0]   res;
        pf = neg ? ({(2*XLEN){1'b0}} - p) : p;
        case (o)
            4'd0:             res = pf[XLEN-1:0];
            4'd1, 4'd2, 4'd3: res = pf[2*XLEN-1:XLEN];
            4'd8:             res = sext32(pf[XLEN-1 -: 32]);
            default:          res = ZERO;
        endcase
        return res;
    endfunction

    function automatic logic [XLEN-1:0] div_result(input logic [XLEN-1:0] q, input logic [XLEN-1:0] rm,
                                                   input logic sa, input logic sb, input logic [3:0] o);
        logic            neg;
        logic [31:0]     v32;
        logic [XLEN-1:0] v;
        neg = o[1] ? sa : (sa ^ sb);
        v32 = o[1] ? rm[31:0] : q[31:0];
        v32 = neg ? (32'd0 - v32) : v32;
        v   = o[1] ? rm : q;
        v   = neg ? (ZERO - v) : v;
        return o[3] ? sext32(v32) : v;
    endfunction

    state_t          r_state;
    logic            r_prep;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_a, r_b;
    logic [XLEN-1:0] r_hi, r_lo, r_d;
    logic            r_sa, r_sb;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_c;

    logic            w_is_w, w_is_div, w_is_rem, w_a_sgn;
    logic            w_sa, w_sb, w_div_zero, w_div_ovf;
    logic [XLEN-1:0] w_ma, w_mb, w_dvd, w_fix_c;
    logic            w_early;
    logic [XLEN-1:0] w_early_c;
    logic [XLEN:0]   w_sum, w_rsh;
    logic [XLEN+1:0] w_diff;

    assign w_is_w     = r_op[3];
    assign w_is_div   = r_op[2];
    assign w_is_rem   = r_op[1];
    assign w_a_sgn    = a_signed(r_op);
    assign w_sa       = w_a_sgn & (w_is_w ? r_a[31] : r_a[XLEN-1]);
    assign w_sb       = b_signed(r_op) & (w_is_w ? r_b[31] : r_b[XLEN-1]);
    assign w_ma       = mag(r_a, w_sa, w_is_w);
    assign w_mb       = mag(r_b, w_sb, w_is_w);
    assign w_dvd      = w_is_w ? sext32(r_a[31:0]) : r_a;
    assign w_div_zero = w_is_w ? (r_b[31:0] == 32'd0) : (r_b == ZERO);
    assign w_div_ovf  = w_a_sgn & (w_is_w ? ((r_a[31:0] == 32'h8000_0000) && (r_b[31:0] == 32'hFFFF_FFFF))
                                          : ((r_a == MOST_NEG) && (r_b == ALL_ONES)));

    assign w_sum  = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_d : ZERO)};
    assign w_rsh  = {r_hi, r_lo[XLEN-1]};
    assign w_diff = {1'b0, w_rsh} - {2'b00, r_d};

    assign w_fix_c = w_is_div ? div_result(r_lo, r_hi, r_sa, r_sb, r_op)
                              : mul_result({r_hi, r_lo}, r_sa ^ r_sb, r_op);

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_prod_full, w_fast_prod;
    assign w_prod_full = {ZERO, w_ma} * {ZERO, w_mb};
    assign w_fast_prod = w_is_w ? (w_prod_full << (XLEN - 32)) : w_prod_full;
`endif

    // Operations finished in the decode cycle: illegal op, divide by zero, signed overflow.
    always_comb begin
        w_early   = 1'b0;
        w_early_c = ZERO;
        if (!op_legal(r_op)) begin
            w_early   = 1'b1;
            w_early_c = ZERO;
        end else if (w_is_div) begin
            if (w_div_zero) begin
                w_early   = 1'b1;
                w_early_c = w_is_rem ? w_dvd : ALL_ONES;
            end else if (w_div_ovf) begin
                w_early   = 1'b1;
                w_early_c = w_is_rem ? ZERO : w_dvd;
            end else begin
                w_early   = 1'b0;
                w_early_c = ZERO;
            end
        end else begin
`ifdef MDU_FAST_MUL_EN
            w_early   = 1'b1;
            w_early_c = mul_result(w_fast_prod, w_sa ^ w_sb, r_op);
`else
            w_early   = 1'b0;
            w_early_c = ZERO;
`endif
        end
    end

    // Control FSM and datapath; the first BUSY cycle registers operand magnitudes before iterating.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_prep      <= 1'b0;
            r_cnt       <= {CW{1'b0}};
            r_op        <= 4'd0;
            r_a         <= ZERO;
            r_b         <= ZERO;
            r_hi        <= ZERO;
            r_lo        <= ZERO;
            r_d         <= ZERO;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_c     <= ZERO;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_prep      <= 1'b0;
            r_cnt       <= {CW{1'b0}};
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_prep  <= 1'b1;
                        r_cnt   <= op[3] ? CNT_W : CNT_FULL;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_prep) begin
                        r_prep <= 1'b0;
                        r_sa   <= w_sa;
                        r_sb   <= w_sb;
                        r_hi   <= ZERO;
                        if (w_early) begin
                            r_out_c     <= w_early_c;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_is_div) begin
                            r_lo <= w_is_w ? (w_ma << (XLEN - 32)) : w_ma;
                            r_d  <= w_mb;
                        end else begin
                            r_lo <= w_mb;
                            r_d  <= w_ma;
                        end
                    end else begin
                        if (w_is_div) begin
                            r_hi <= w_diff[XLEN+1] ? w_rsh[XLEN-1:0] : w_diff[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN+1]};
                        end else begin
                            r_hi <= w_sum[XLEN:1];
                            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                        end
                        if (r_cnt == {CW{1'b0}}) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_FIX: begin
                    r_out_c     <= w_fix_c;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_c     = r_out_c;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table, randomized model checks, corner sequences.
module tb_mdu_iter;

    logic        clk, resetn, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [3:0]  op;
    logic [63:0] a, b, out_c;

    int checks = 0;
    int errors = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int LM  = 1;
    localparam int LMW = 1;
`else
    localparam int LM  = 66;
    localparam int LMW = 34;
`endif
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] c;
        int          lat;
    } exp_t;

    exp_t sb[$];

    mdu_iter #(.XLEN(64)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_c(out_c), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] ref_c(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        logic signed [127:0] px, py;
        logic [127:0] p;
        logic [31:0]  x32, y32, t32;
        logic [63:0]  r;
        x32 = x[31:0];
        y32 = y[31:0];
        r   = 64'd0;
        case (o)
            4'd0: begin p = {64'd0, x} * {64'd0, y}; r = p[63:0]; end
            4'd1: begin px = {{64{x[63]}}, x}; py = {{64{y[63]}}, y}; p = px * py; r = p[127:64]; end
            4'd2: begin px = {{64{x[63]}}, x}; py = {64'd0, y}; p = px * py; r = p[127:64]; end
            4'd3: begin p = {64'd0, x} * {64'd0, y}; r = p[127:64]; end
            4'd4: if (y == 64'd0) r = ONES; else if (x == MIN && y == ONES) r = x; else r = $signed(x) / $signed(y);
            4'd5: if (y == 64'd0) r = ONES; else r = x / y;
            4'd6: if (y == 64'd0) r = x; else if (x == MIN && y == ONES) r = 64'd0; else r = $signed(x) % $signed(y);
            4'd7: if (y == 64'd0) r = x; else r = x % y;
            4'd8: begin t32 = x32 * y32; r = sx(t32); end
            4'd12: if (y32 == 32'd0) r = ONES;
                   else if (x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF) r = sx(x32);
                   else begin t32 = $signed(x32) / $signed(y32); r = sx(t32); end
            4'd13: if (y32 == 32'd0) r = ONES; else begin t32 = x32 / y32; r = sx(t32); end
            4'd14: if (y32 == 32'd0) r = sx(x32);
                   else if (x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF) r = 64'd0;
                   else begin t32 = $signed(x32) % $signed(y32); r = sx(t32); end
            4'd15: if (y32 == 32'd0) r = sx(x32); else begin t32 = x32 % y32; r = sx(t32); end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        logic w, zero, ovf, sgn;
        w    = o[3];
        zero = w ? (y[31:0] == 32'd0) : (y == 64'd0);
        sgn  = (o == 4'd4) || (o == 4'd6) || (o == 4'd12) || (o == 4'd14);
        ovf  = sgn && (w ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF) : (x == MIN && y == ONES));
        if (o == 4'd9 || o == 4'd10 || o == 4'd11) return 1;
        if (o[2]) return (zero || ovf) ? 1 : (w ? 34 : 66);
        return w ? LMW : LM;
    endfunction

    task automatic run_op(input string nm, input logic [3:0] o, input logic [63:0] xa, input logic [63:0] xb,
                          input logic [63:0] ec, input int el);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_ready"}, {63'd0, in_ready}, 64'd1);
        sb.push_back('{ec, el});
        in_valid = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!out_valid && n < 200);
        e = sb.pop_front();
        chk({nm, "_lat"}, 64'(n), 64'(e.lat));
        chk({nm, "_val"}, out_c, e.c);
        @(posedge clk); #1;
    endtask

    vec_t tbl[17];
    logic [3:0] ops[14];

    initial begin
        logic [63:0] ra, rb, held;
        logic [3:0]  ro;
        int          seen;

        tbl[0]  = '{4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, LM};
        tbl[1]  = '{4'd1,  MIN, MIN, 64'h4000_0000_0000_0000, LM};
        tbl[2]  = '{4'd8,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LMW};
        tbl[3]  = '{4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        tbl[4]  = '{4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66};
        tbl[5]  = '{4'd5,  64'd100, 64'd7, 64'd14, 66};
        tbl[6]  = '{4'd15, 64'd100, 64'd7, 64'd2, 34};
        tbl[7]  = '{4'd4,  64'd5, 64'd0, ONES, 1};
        tbl[8]  = '{4'd6,  64'd5, 64'd0, 64'd5, 1};
        tbl[9]  = '{4'd4,  MIN, ONES, MIN, 1};
        tbl[10] = '{4'd6,  MIN, ONES, 64'd0, 1};
        tbl[11] = '{4'd3,  ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, LM};
        tbl[12] = '{4'd2,  ONES, 64'd2, ONES, LM};
        tbl[13] = '{4'd12, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        tbl[14] = '{4'd14, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 34};
        tbl[15] = '{4'd15, 64'h1_8000_0000, 64'h5_0000_0000, 64'hFFFF_FFFF_8000_0000, 1};
        tbl[16] = '{4'd9,  64'd3, 64'd4, 64'd0, 1};
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12, 4'd13, 4'd14, 4'd15, 4'd10};

        resetn = 1'b0; in_valid = 1'b0; op = 4'd0; a = 64'd0; b = 64'd0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_c", out_c, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            ro = ops[$urandom_range(0, 13)];
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = 64'd0;
                1: rb = 64'($urandom_range(1, 15));
                2: begin ra = MIN; rb = ONES; end
                3: begin ra = 64'hFFFF_FFFF_8000_0000; rb = ONES; end
                default: ;
            endcase
            run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, ref_c(ro, ra, rb), ref_lat(ro, ra, rb));
        end

        // Backpressure on a held result.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'd4; a = 64'd5; b = 64'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_valid_rise", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_hold", {63'd0, out_valid}, 64'd1);
            chk("bp_c_hold", out_c, ONES);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_c_kept", out_c, ONES);

        // Flush ten cycles into a divide.
        in_valid = 1'b1; op = 4'd5; a = 64'd100; b = 64'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);
        run_op("after_flush_mul", 4'd0, 64'd3, 64'd4, 64'd12, LM);

        // Request presented together with flush in IDLE is dropped.
        in_valid = 1'b1; flush = 1'b1; op = 4'd4; a = 64'd5; b = 64'd0;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("flush_idle_valid", {63'd0, out_valid}, 64'd0);

        // Flush in DONE with out_ready high discards the result.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'd6; a = 64'd9; b = 64'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("flush_done_pre", {63'd0, out_valid}, 64'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_done_ready", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset in the middle of an iterative operation.
        in_valid = 1'b1; op = 4'd4; a = 64'd1000; b = 64'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        held = out_c;
        chk("pre_rst_c", held, 64'd9);
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_c", out_c, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst_div", 4'd4, 64'd1000, 64'd3, 64'd333, 66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
